// File: rtl/td4_io_pkg.sv
// Shared types and constants for the TD4 input conditioning slice.
package td4_io_pkg;

  localparam int unsigned TD4_DATA_W = 4;

  typedef enum logic {
    DB_IDLE,
    DB_COUNT
  } db_state_e;

endpackage

// File: rtl/td4_debounce_bit.sv
// Single-bit debouncer: output follows the synced input only after it has
// differed for DEBOUNCE_CYCLES consecutive clock edges.
module td4_debounce_bit
  import td4_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic out,
  output logic busy,
  output logic update
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  db_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            out_q;
  logic            differ;

  assign differ = sync_in != out_q;

  // Strobe on the edge where out_q takes the new value.
  always_comb begin
    update = 1'b0;
    if (differ) begin
      if (DEBOUNCE_CYCLES == 1) begin
        update = 1'b1;
      end else if (state_q == DB_COUNT && cnt_q == CntLast) begin
        update = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      unique case (state_q)
        DB_IDLE: begin
          cnt_q <= '0;
          if (differ) begin
            if (DEBOUNCE_CYCLES == 1) begin
              out_q <= sync_in;
            end else begin
              state_q <= DB_COUNT;
              cnt_q   <= CntOne;
            end
          end
        end
        DB_COUNT: begin
          if (!differ) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            out_q   <= sync_in;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= DB_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = state_q == DB_COUNT;

endmodule

// File: rtl/td4_input_cond.sv
// TD4 input conditioning: 2-flop sync, per-bit debounce, change/busy status.
// Optional sticky rising-edge flags when TD4_INPUT_EDGE_LATCH_EN is defined.
module td4_input_cond
  import td4_io_pkg::*;
#(
  parameter int unsigned WIDTH           = TD4_DATA_W,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] inp_out,
  output logic             change,
  output logic             busy
`ifdef TD4_INPUT_EDGE_LATCH_EN
  ,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] rise_flags
`endif
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] bit_busy;
  logic [WIDTH-1:0] bit_update;
  logic             change_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    td4_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .sync_in(s2_q[i]),
      .out    (inp_out[i]),
      .busy   (bit_busy[i]),
      .update (bit_update[i])
    );
  end

  // Simultaneous bit updates collapse into one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_q <= 1'b0;
    end else begin
      change_q <= |bit_update;
    end
  end

  assign change = change_q;
  assign busy   = |bit_busy;

`ifdef TD4_INPUT_EDGE_LATCH_EN
  logic [WIDTH-1:0] rise_q;

  // A rise landing on the clear edge is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
    end else begin
      rise_q <= (clr_flags ? '0 : rise_q) | (bit_update & s2_q);
    end
  end

  assign rise_flags = rise_q;
`endif

endmodule

// File: tb/tb_td4_input_cond.sv
// Scoreboarded bench for td4_input_cond (WIDTH=4, DEBOUNCE_CYCLES=4):
// directed scenarios plus randomized stimulus against a windowed reference model.
module tb_td4_input_cond;

  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] inp_out;
  logic         change;
  logic         busy;
`ifdef TD4_INPUT_EDGE_LATCH_EN
  logic         clr_flags;
  logic [W-1:0] rise_flags;
`endif

  td4_input_cond #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_in),
    .inp_out(inp_out),
    .change (change),
    .busy   (busy)
`ifdef TD4_INPUT_EDGE_LATCH_EN
    ,
    .clr_flags (clr_flags),
    .rise_flags(rise_flags)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic         chg;
    logic         bsy;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_s1 = '0;
  logic [W-1:0] m_s2 = '0;
  logic [W-1:0] m_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Model: a bit takes the synced value once the last N synced samples all differ from it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0;
      m_s2 = '0;
      m_out = '0;
      hist.delete();
    end else begin : model_step
      logic [W-1:0] prev, upd, bsy;
      logic         all_diff;
      exp_t         e;
      hist.push_back(m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      prev = m_out;
      upd = '0;
      bsy = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = (hist.size() == N);
        for (int k = 0; k < hist.size(); k++) if (hist[k][i] == prev[i]) all_diff = 1'b0;
        if (all_diff) begin
          upd[i] = 1'b1;
          m_out[i] = ~prev[i];
        end else if (hist[hist.size()-1][i] != prev[i]) begin
          bsy[i] = 1'b1;
        end
      end
      e.out = m_out;
      e.chg = |upd;
      e.bsy = |bsy;
      exp_q.push_back(e);
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  end

  // Monitor: compare every post-edge output against the queued expectation.
  always @(posedge clk) begin
    if (reset) begin : mon_step
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
        check("sb_queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_inp_out", 32'(inp_out), 32'(e.out));
        check("sb_change", 32'(change), 32'(e.chg));
        check("sb_busy", 32'(busy), 32'(e.bsy));
      end
    end
  end

  // Edge index (0 = first edge after the call) where inp_out first equals v.
  task automatic wait_value(input logic [W-1:0] v, input int req_edge, input string name);
    int found;
    found = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (inp_out === v) begin
        found = e;
        break;
      end
    end
    check(name, 32'(found), 32'(req_edge));
    check({name, "_chg_on"}, 32'(change), 32'd1);
    @(posedge clk);
    #1;
    check({name, "_chg_off"}, 32'(change), 32'd0);
  endtask

  task automatic settle(input logic [W-1:0] v);
    @(negedge clk);
    raw_in = v;
    repeat (N + 6) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int saw_busy, n_chg, n_odd;
    reset = 1'b0;
    raw_in = '0;
`ifdef TD4_INPUT_EDGE_LATCH_EN
    clr_flags = 1'b0;
`endif
    // 1: held in reset with raw F, then release
    @(negedge clk);
    raw_in = 4'hF;
    repeat (3) @(negedge clk);
    check("t1_rst_inp", 32'(inp_out), 32'h0);
    check("t1_rst_chg", 32'(change), 32'h0);
    check("t1_rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    wait_value(4'hF, 5, "t1_edge");

    // 2: 0 -> 5
    settle(4'h0);
    @(negedge clk);
    raw_in = 4'h5;
    wait_value(4'h5, 5, "t2_edge");

    // 3: 2-cycle glitch on bit 0 is rejected
    settle(4'h0);
    @(negedge clk);
    raw_in = 4'h1;
    repeat (2) @(negedge clk);
    raw_in = 4'h0;
    saw_busy = 0;
    n_chg = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1;
      if (change) n_chg++;
    end
    check("t3_busy_seen", 32'(saw_busy), 32'd1);
    check("t3_no_change", 32'(n_chg), 32'd0);
    check("t3_inp", 32'(inp_out), 32'h0);
    check("t3_busy_end", 32'(busy), 32'd0);

    // 4: reset mid-bounce from 5 toward A
    settle(4'h5);
    @(negedge clk);
    raw_in = 4'hA;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t4_rst_inp", 32'(inp_out), 32'h0);
    check("t4_rst_chg", 32'(change), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_value(4'hA, 5, "t4_edge");

    // 5: bits 1 and 3 together, A -> 0
    repeat (4) @(negedge clk);
    raw_in = 4'h0;
    n_chg = 0;
    n_odd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (change) n_chg++;
      if (inp_out != 4'hA && inp_out != 4'h0) n_odd++;
    end
    check("t5_one_pulse", 32'(n_chg), 32'd1);
    check("t5_no_split", 32'(n_odd), 32'd0);
    check("t5_inp", 32'(inp_out), 32'h0);

`ifdef TD4_INPUT_EDGE_LATCH_EN
    // 6: sticky rise flags, set beats clear
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    raw_in = 4'h4;
    wait_value(4'h4, 5, "t6_edge");
    check("t6_rise4", 32'(rise_flags), 32'h4);
    @(negedge clk);
    raw_in = 4'h5;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    check("t6_inp5", 32'(inp_out), 32'h5);
    check("t6_rise1", 32'(rise_flags), 32'h1);
    @(negedge clk);
    clr_flags = 1'b0;
`endif

    // Randomized: holds, single-bit flips, bursts, occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 19))
        0, 1, 2: raw_in = 4'($urandom);
        3, 4, 5: raw_in = raw_in ^ (4'h1 << $urandom_range(0, W - 1));
        6: begin
          if ($urandom_range(0, 9) == 0) begin
            reset = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            reset = 1'b1;
          end
        end
        default: ;
      endcase
    end
    settle(raw_in);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
